// File: rtl/matmul_pkg.sv
// matmul_pkg: host FSM encoding, default matrix dimensions
// and a small address-width helper shared by the host slice.
package matmul_pkg;

  localparam int M_D = 25;
  localparam int N_D = 19;
  localparam int L_D = 17;

  localparam int A_LEN = M_D * N_D;
  localparam int B_LEN = N_D * L_D;
  localparam int C_LEN = M_D * L_D;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND_A,
    ST_SEND_B,
    ST_RECV_C,
    ST_DONE
  } state_t;

  function automatic int addr_bits(input int n);
    int b;
    b = 1;
    while ((1 << b) < n) b++;
    return b;
  endfunction

endpackage

// File: rtl/axis_buf_streamer.sv
// axis_buf_streamer: load-port buffer replayed row-major
// as an AXIS master while go is held high.
module axis_buf_streamer #(
  parameter int DEPTH = 475,
  parameter int DW    = 8,
  parameter int AW    = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_go,
  input  logic          i_clr,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_tready,
  output logic [DW-1:0] o_tdata,
  output logic          o_tvalid,
  output logic          o_tlast,
  output logic          o_last_hs
);

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  logic [DW-1:0] r_mem [2**AW];
  logic [AW-1:0] r_idx;
  logic          w_hs;
  logic          w_at_last;

  assign w_hs      = i_go & i_tready;
  assign w_at_last = (r_idx == LAST);

  always_ff @(posedge clk) begin
    if (i_we && (i_waddr <= LAST))
      r_mem[i_waddr] <= i_wdata;
  end

  // index wraps on the final beat so the next run starts at 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_idx <= '0;
    else if (i_clr)
      r_idx <= '0;
    else if (w_hs)
      r_idx <= w_at_last ? '0 : r_idx + 1'b1;
  end

  assign o_tvalid  = i_go;
  assign o_tdata   = i_go ? r_mem[r_idx] : '0;
  assign o_tlast   = i_go & w_at_last;
  assign o_last_hs = w_hs & w_at_last;

endmodule

// File: rtl/matmul_axis_host.sv
// matmul_axis_host: streams A then B, collects C into a readable buffer.
// MATMUL_HOST_TIMEOUT_EN adds a stall watchdog driving err_timeout.
module matmul_axis_host
  import matmul_pkg::*;
#(
  parameter int M       = M_D,
  parameter int N       = N_D,
  parameter int L       = L_D,
  parameter int DW      = 8,
  parameter int OW      = 16,
  parameter int AW      = 10,
  parameter int TIMEOUT = 4096
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          err_len,
  output logic          err_timeout,
  input  logic          ld_en,
  input  logic          ld_sel,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_data,
  input  logic [AW-1:0] rd_addr,
  output logic [OW-1:0] rd_data,
  output logic [DW-1:0] m_axis_a_tdata,
  output logic          m_axis_a_tvalid,
  input  logic          m_axis_a_tready,
  output logic          m_axis_a_tlast,
  output logic [DW-1:0] m_axis_b_tdata,
  output logic          m_axis_b_tvalid,
  input  logic          m_axis_b_tready,
  output logic          m_axis_b_tlast,
  input  logic [OW-1:0] s_axis_c_tdata,
  input  logic          s_axis_c_tvalid,
  output logic          s_axis_c_tready,
  input  logic          s_axis_c_tlast
);

  localparam int LEN_A = M * N;
  localparam int LEN_B = N * L;
  localparam int LEN_C = M * L;
  localparam logic [AW-1:0] C_LAST = AW'(LEN_C - 1);

  state_t        r_state;
  state_t        w_nxt;
  logic          w_start;
  logic          w_a_go;
  logic          w_b_go;
  logic          w_a_last;
  logic          w_b_last;
  logic          w_c_hs;
  logic          w_c_lastb;
  logic          w_c_end;
  logic          w_len_bad;
  logic          w_to;
  logic          w_we_a;
  logic          w_we_b;
  logic [AW-1:0] r_cidx;
  logic [OW-1:0] r_cmem [2**AW];

  assign w_start   = (r_state == ST_IDLE) & start;
  assign w_c_hs    = s_axis_c_tvalid & s_axis_c_tready;
  assign w_c_lastb = (r_cidx == C_LAST);
  assign w_c_end   = w_c_hs & (s_axis_c_tlast | w_c_lastb);
  // tlast must coincide exactly with the final beat
  assign w_len_bad = w_c_hs & (s_axis_c_tlast ^ w_c_lastb);
  assign w_we_a    = ld_en & ~busy & ~ld_sel;
  assign w_we_b    = ld_en & ~busy & ld_sel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_state <= ST_IDLE;
    else
      r_state <= w_nxt;
  end

  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      ST_IDLE:   if (start) w_nxt = ST_SEND_A;
      ST_SEND_A: begin
        if (w_to)          w_nxt = ST_DONE;
        else if (w_a_last) w_nxt = ST_SEND_B;
      end
      ST_SEND_B: begin
        if (w_to)          w_nxt = ST_DONE;
        else if (w_b_last) w_nxt = ST_RECV_C;
      end
      ST_RECV_C: if (w_c_end || w_to) w_nxt = ST_DONE;
      ST_DONE:   w_nxt = ST_IDLE;
      default:   w_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy            = 1'b0;
    done            = 1'b0;
    w_a_go          = 1'b0;
    w_b_go          = 1'b0;
    s_axis_c_tready = 1'b0;
    unique case (r_state)
      ST_SEND_A: begin
        busy   = 1'b1;
        w_a_go = 1'b1;
      end
      ST_SEND_B: begin
        busy   = 1'b1;
        w_b_go = 1'b1;
      end
      ST_RECV_C: begin
        busy            = 1'b1;
        s_axis_c_tready = 1'b1;
      end
      ST_DONE:   done = 1'b1;
      default:   ;
    endcase
  end

  axis_buf_streamer #(
    .DEPTH (LEN_A),
    .DW    (DW),
    .AW    (AW)
  ) u_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_go      (w_a_go),
    .i_clr     (w_start),
    .i_we      (w_we_a),
    .i_waddr   (ld_addr),
    .i_wdata   (ld_data),
    .i_tready  (m_axis_a_tready),
    .o_tdata   (m_axis_a_tdata),
    .o_tvalid  (m_axis_a_tvalid),
    .o_tlast   (m_axis_a_tlast),
    .o_last_hs (w_a_last)
  );

  axis_buf_streamer #(
    .DEPTH (LEN_B),
    .DW    (DW),
    .AW    (AW)
  ) u_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_go      (w_b_go),
    .i_clr     (w_start),
    .i_we      (w_we_b),
    .i_waddr   (ld_addr),
    .i_wdata   (ld_data),
    .i_tready  (m_axis_b_tready),
    .o_tdata   (m_axis_b_tdata),
    .o_tvalid  (m_axis_b_tvalid),
    .o_tlast   (m_axis_b_tlast),
    .o_last_hs (w_b_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_cidx <= '0;
    else if (w_start)
      r_cidx <= '0;
    else if (w_c_hs)
      r_cidx <= r_cidx + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (w_c_hs)
      r_cmem[r_cidx] <= s_axis_c_tdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      rd_data <= '0;
    else
      rd_data <= (rd_addr <= C_LAST) ? r_cmem[rd_addr] : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      err_len <= 1'b0;
    else if (w_start)
      err_len <= 1'b0;
    else if (w_len_bad)
      err_len <= 1'b1;
  end

`ifdef MATMUL_HOST_TIMEOUT_EN
  localparam int WDW = addr_bits(TIMEOUT + 1) + 1;
  localparam logic [WDW-1:0] TO_V = WDW'(TIMEOUT);

  logic [WDW-1:0] r_wd;
  logic           w_wd_inc;
  logic           r_err_to;

  // counts cycles the active stream makes no progress
  assign w_wd_inc = ((r_state == ST_RECV_C) & ~w_c_hs)
                  | ((r_state == ST_SEND_A) & ~m_axis_a_tready)
                  | ((r_state == ST_SEND_B) & ~m_axis_b_tready);
  assign w_to     = (r_wd == TO_V);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_wd <= '0;
    else if (!w_wd_inc || w_to)
      r_wd <= '0;
    else
      r_wd <= r_wd + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_err_to <= 1'b0;
    else if (w_start)
      r_err_to <= 1'b0;
    else if (w_to)
      r_err_to <= 1'b1;
  end

  assign err_timeout = r_err_to;
`else
  assign w_to        = 1'b0;
  assign err_timeout = 1'b0;
`endif

endmodule
